// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package adder_ctrl_pkg;

   localparam int unsigned NIBBLE_W = 4;

   // 2'd3 is unused and recovers to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : adder_ctrl_pkg

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result valid-ready bus of the nibble-serial adder.
interface nibble_serial_adder_ctrl_if
   import adder_ctrl_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
);

   localparam int unsigned W = NIBBLE_W * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, busy
   );

endinterface : nibble_serial_adder_ctrl_if

// File: rtl/nibble_serial_adder_ctrl_rca4_slice.sv
// Combinational 4-bit ripple-carry adder built from full-adder cells.
module rca4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c;

   assign c[0] = ci;

   // One full-adder cell per bit, carry rippling upward
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

   assign co = c[4];

endmodule : rca4_slice

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two NIBBLES*4-bit operands one nibble per cycle, LSB nibble first.
module nibble_serial_adder_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   nibble_serial_adder_ctrl_if.slave   bus
);

   localparam int unsigned W        = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b, slice_s;
   logic                slice_co;

   // Nibble select on the registered operands
   assign nib_a = a_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];
   assign nib_b = b_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];

   rca4_slice u_slice (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic; handshake flags follow the next state
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               carry_d = bus.in_cin;
               idx_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d[32'(idx_q) * NIBBLE_W +: NIBBLE_W] = slice_s;
            carry_d = slice_co;
            if (idx_q == IDX_LAST) begin
               cout_d      = slice_co;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.busy      = busy_q;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for the nibble-serial adder: directed cases plus random operations.
module tb_nibble_serial_adder_ctrl;
   import adder_ctrl_pkg::*;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = NIBBLE_W * NIBBLES;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: plain wide addition, {cout, sum}
   function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait for accept, check latency/result, hold in DONE, handshake
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int hold);
      int n;
      logic [W:0] exp;
      logic [W-1:0] sum_seen;
      logic cout_seen;
      exp = model_add(a, b, cin);
      bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin step(); n++; end
      check({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      check({tag, "_busy_ready"}, {62'd0, bus.busy, bus.in_ready}, 64'b10);
      n = 0;
      while (!bus.out_valid && n < 40) begin step(); n++; end
      check({tag, "_latency"}, 64'(n), 64'(NIBBLES));
      check({tag, "_sum"}, 64'(bus.out_sum), 64'(exp[W-1:0]));
      check({tag, "_cout"}, 64'(bus.out_cout), 64'(exp[W]));
      sum_seen  = bus.out_sum;
      cout_seen = bus.out_cout;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_a     = W'($urandom);
         bus.in_b     = W'($urandom);
         step();
         check({tag, "_hold_state"},
               {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b101);
         check({tag, "_hold_data"}, {47'd0, cout_seen, sum_seen},
               {47'd0, bus.out_cout, bus.out_sum});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_after_hs"}, {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
      step();
      check({tag, "_no_capture"}, {62'd0, bus.out_valid, bus.busy}, 64'd0);
   endtask

   initial begin
      int n;
      logic [W:0] exp;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #3;
      check("rst_flags", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd0);
      check("rst_data", {47'd0, bus.out_cout, bus.out_sum}, 64'd0);
      step();
      check("rst_ready_low", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b1;
      step();
      check("rst_ready_after", 64'(bus.in_ready), 64'd1);

      // Directed cases
      run_op("t1", 16'h1234, 16'h4321, 1'b0, 0);
      run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 0);
      run_op("t3", 16'hFFFF, 16'hFFFF, 1'b1, 1);
      run_op("t4", 16'hA5C3, 16'h3C5A, 1'b1, 5);

      // Reset in the middle of ADD
      bus.in_a = 16'h7777; bus.in_b = 16'h8888; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin step(); n++; end
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("t5_rst_flags", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd0);
      check("t5_rst_data", {47'd0, bus.out_cout, bus.out_sum}, 64'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("t5_no_valid", 64'(bus.out_valid), 64'd0);
      end
      run_op("t5", 16'h0F0F, 16'h00F1, 1'b0, 0);

      // Back-to-back with in_valid held and out_ready high
      bus.out_ready = 1'b1;
      bus.in_a = 16'h0001; bus.in_b = 16'h0002; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin step(); n++; end
      step();
      bus.in_a = 16'h8000; bus.in_b = 16'h8000;
      repeat (3) step();
      check("t6_not_yet", 64'(bus.out_valid), 64'd0);
      step();
      exp = model_add(16'h0001, 16'h0002, 1'b0);
      check("t6_r1", {47'd0, bus.out_valid, bus.out_sum}, {47'd0, 1'b1, exp[W-1:0]});
      check("t6_r1_cout", 64'(bus.out_cout), 64'(exp[W]));
      step();
      check("t6_hs", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
      step();
      check("t6_accept2", {62'd0, bus.in_ready, bus.busy}, 64'b01);
      bus.in_valid = 1'b0;
      repeat (4) step();
      exp = model_add(16'h8000, 16'h8000, 1'b0);
      check("t6_r2", {47'd0, bus.out_valid, bus.out_sum}, {47'd0, 1'b1, exp[W-1:0]});
      check("t6_r2_cout", 64'(bus.out_cout), 64'(exp[W]));
      step();
      check("t6_hs2", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b0;
      step();

      // Random operations
      for (int i = 0; i < 20; i++) begin
         run_op("rnd", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_nibble_serial_adder_ctrl
